// File: rtl/sm3_msg_expand.sv
`timescale 1ns/1ps
// SM3 message expansion: 16 words in, 64 (W_j, W'_j) pairs out; SM3_MSG_EXPAND_EXT_P1_EN routes P1 to a shared external unit.
// Latency: first pair the cycle after the 16th word accept; 80 cycles per block at full throughput.
// Backpressure: out_ready low freezes window, idx and outputs; in_ready is low while expanding.
module sm3_msg_expand (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_w,
    output logic [31:0] out_wp,
    output logic [5:0]  out_idx,
`ifdef SM3_MSG_EXPAND_EXT_P1_EN
    output logic [31:0] p1_rs1,
    input  logic [31:0] p1_res,
`endif
    output logic        busy
);

    typedef enum logic {
        S_LOAD   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_win [16];
    logic [3:0]  r_ld_cnt;
    logic [5:0]  r_idx;

    logic        w_in_fire;
    logic        w_out_fire;
    logic [31:0] w_p1_in;
    logic [31:0] w_p1_out;
    logic [31:0] w_nw;

    assign in_ready   = (r_state == S_LOAD);
    assign out_valid  = (r_state == S_EXPAND);
    assign busy       = out_valid;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Outputs read straight from registers so they hold steady under backpressure.
    assign out_w   = out_valid ? r_win[0] : 32'h0;
    assign out_wp  = out_valid ? (r_win[0] ^ r_win[4]) : 32'h0;
    assign out_idx = r_idx;

    assign w_p1_in = r_win[0] ^ r_win[7] ^ {r_win[13][16:0], r_win[13][31:17]};

`ifdef SM3_MSG_EXPAND_EXT_P1_EN
    assign p1_rs1   = w_p1_in;
    assign w_p1_out = p1_res;
`else
    assign w_p1_out = w_p1_in ^ {w_p1_in[16:0], w_p1_in[31:17]} ^ {w_p1_in[8:0], w_p1_in[31:9]};
`endif

    assign w_nw = w_p1_out ^ {r_win[3][24:0], r_win[3][31:25]} ^ r_win[10];

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_in_fire && (r_ld_cnt == 4'd15)) begin
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (w_out_fire && (r_idx == 6'd63)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
        if (flush) begin
            w_state_nxt = S_LOAD;
        end
    end

    // Flush wins over any handshake in the same cycle; the window is left as-is.
    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            r_ld_cnt <= 4'd0;
            r_idx    <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'h0;
            end
        end else if (flush) begin
            r_ld_cnt <= 4'd0;
            r_idx    <= 6'd0;
        end else if (w_in_fire) begin
            r_win[r_ld_cnt] <= in_word;
            r_ld_cnt        <= r_ld_cnt + 4'd1;
            r_idx           <= 6'd0;
        end else if (w_out_fire) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_nw;
            r_idx     <= r_idx + 6'd1;
        end
    end

endmodule

// File: tb/tb_sm3_msg_expand.sv
`timescale 1ns/1ps
// Scoreboard bench for sm3_msg_expand: reference expansion model, backpressure, back-to-back, flush and reset scenarios.
module tb_sm3_msg_expand;

    logic        g_clk = 1'b0;
    logic        g_rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_w;
    logic [31:0] out_wp;
    logic [5:0]  out_idx;
    logic        busy;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] wp;
        logic [5:0]  idx;
    } pair_t;

    pair_t       exp_q[$];
    pair_t       obs_q[$];
    pair_t       stall_q[$];
    logic [31:0] in_q[$];
    logic [31:0] blk[16];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1f(input logic [31:0] x);
        return x ^ rol(x, 15) ^ rol(x, 23);
    endfunction

`ifdef SM3_MSG_EXPAND_EXT_P1_EN
    logic [31:0] p1_rs1;
    logic [31:0] p1_res;
    assign p1_res = p1f(p1_rs1);
`endif

    sm3_msg_expand dut (
        .g_clk     (g_clk),
        .g_rst     (g_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_w     (out_w),
        .out_wp    (out_wp),
        .out_idx   (out_idx),
`ifdef SM3_MSG_EXPAND_EXT_P1_EN
        .p1_rs1    (p1_rs1),
        .p1_res    (p1_res),
`endif
        .busy      (busy)
    );

    always #5 g_clk = ~g_clk;

    // Reference expansion in the textbook W[j-16..j-3] form; queues the block's words and its 64 pairs.
    task automatic push_block();
        logic [31:0] w [68];
        for (int j = 0; j < 16; j++) begin
            w[j] = blk[j];
            in_q.push_back(blk[j]);
        end
        for (int j = 16; j < 68; j++) begin
            w[j] = p1f(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
        end
        for (int j = 0; j < 64; j++) begin
            exp_q.push_back({w[j], w[j] ^ w[j+4], 6'(j)});
        end
    endtask

    task automatic set_abc();
        for (int j = 0; j < 16; j++) blk[j] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        for (int j = 0; j < 16; j++) blk[j] = $urandom;
    endtask

    // mode 0: always ready; 1: random ready; 2: stall 5 cycles at idx 20.
    task automatic run(input int n_pairs, input int mode, input int budget, output int got, output int cyc);
        int stall;
        stall = 0;
        got   = 0;
        cyc   = 0;
        while (got < n_pairs && cyc < budget) begin
            @(negedge g_clk);
            cyc++;
            in_valid = (in_q.size() > 0);
            in_word  = 32'h0;
            if (in_valid) in_word = in_q[0];
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_idx == 6'd20 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                        stall_q.push_back({out_w, out_wp, out_idx});
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (in_valid && in_ready) void'(in_q.pop_front());
            if (out_valid && out_ready) begin
                obs_q.push_back({out_w, out_wp, out_idx});
                got++;
            end
        end
        @(posedge g_clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int got, cyc;
        pair_t e, o;
        g_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = 32'h0;
        #12;
        n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL rst in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_w !== 32'h0 || out_wp !== 32'h0) begin n_err++; $display("FAIL rst out_w/wp: got %h/%h want 0/0", out_w, out_wp); end
        n_cmp++; if (out_idx !== 6'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rst idx/busy: got %0d/%b want 0/0", out_idx, busy); end
        @(negedge g_clk);
        g_rst = 1'b0;
        // Reset arriving mid-expansion
        set_rand();
        push_block();
        run(10, 0, 100, got, cyc);
        #2;
        g_rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst vld/rdy: got %b/%b want 0/1", out_valid, in_ready); end
        n_cmp++; if (out_idx !== 6'd0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst idx/busy: got %0d/%b want 0/0", out_idx, busy); end
        n_cmp++; if (got != 10) begin n_err++; $display("FAIL midrst pre-count: got %0d want 10", got); end
        while (obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL midrst pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete();
        in_q.delete();
        @(negedge g_clk);
        g_rst = 1'b0;
    endtask

    task automatic test_abc(input int mode);
        int got, cyc;
        pair_t e, o;
        set_abc();
        push_block();
        run(64, mode, 1000, got, cyc);
        n_cmp++; if (got != 64) begin n_err++; $display("FAIL abc count: got %0d want 64", got); end
        if (mode == 0) begin
            n_cmp++; if (cyc != 80) begin n_err++; $display("FAIL abc cycles: got %0d want 80", cyc); end
        end
        if (obs_q.size() >= 17) begin
            n_cmp++; if (obs_q[0].w !== 32'h61626380 || obs_q[0].wp !== 32'h61626380) begin
                n_err++; $display("FAIL abc idx0: got %h/%h want 61626380/61626380", obs_q[0].w, obs_q[0].wp); end
            n_cmp++; if (obs_q[12].wp !== 32'h9092e200) begin n_err++; $display("FAIL abc idx12 wp: got %h want 9092e200", obs_q[12].wp); end
            n_cmp++; if (obs_q[16].w !== 32'h9092e200) begin n_err++; $display("FAIL abc idx16 w: got %h want 9092e200", obs_q[16].w); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL abc pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
    endtask

    task automatic test_backpressure();
        int got, cyc;
        pair_t e, o, e20;
        set_rand();
        push_block();
        e20 = exp_q[20];
        stall_q.delete();
        run(64, 2, 300, got, cyc);
        n_cmp++; if (got != 64 || stall_q.size() != 5) begin n_err++; $display("FAIL bp counts: got %0d pairs %0d stalls want 64/5", got, stall_q.size()); end
        while (stall_q.size() > 0) begin
            o = stall_q.pop_front();
            n_cmp++;
            if (o !== e20) begin n_err++; $display("FAIL bp stall hold: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e20.w, e20.wp, e20.idx); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL bp pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
        // Random out_ready over a whole block
        set_rand();
        push_block();
        run(64, 1, 1000, got, cyc);
        n_cmp++; if (got != 64) begin n_err++; $display("FAIL bp rand count: got %0d want 64", got); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL bp rand pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
    endtask

    task automatic test_back_to_back();
        int got, cyc;
        pair_t e, o;
        set_rand();
        push_block();
        set_rand();
        push_block();
        run(128, 0, 400, got, cyc);
        n_cmp++; if (got != 128 || cyc != 160) begin n_err++; $display("FAIL b2b timing: got %0d pairs in %0d cycles want 128 in 160", got, cyc); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL b2b pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
    endtask

    task automatic test_flush();
        int got, cyc;
        pair_t e, o;
        // Flush during load after 9 words, together with a 10th word
        for (int i = 0; i < 10; i++) begin
            @(negedge g_clk);
            in_valid = 1'b1;
            in_word  = $urandom;
            flush    = (i == 9);
        end
        @(negedge g_clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush load state: got rdy %b vld %b want 1/0", in_ready, out_valid); end
        set_rand();
        push_block();
        run(64, 0, 200, got, cyc);
        n_cmp++; if (got != 64 || cyc != 80) begin n_err++; $display("FAIL flush load timing: got %0d pairs in %0d cycles want 64 in 80", got, cyc); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL flush load pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
        // Flush together with an output handshake at idx 40
        set_rand();
        push_block();
        run(40, 0, 200, got, cyc);
        @(negedge g_clk);
        n_cmp++; if (out_idx !== 6'd40 || out_valid !== 1'b1) begin n_err++; $display("FAIL flush pre idx: got %0d/%b want 40/1", out_idx, out_valid); end
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge g_clk);
        out_ready = 1'b0;
        flush     = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL flush exp state: got vld %b rdy %b busy %b want 0/1/0", out_valid, in_ready, busy); end
        n_cmp++; if (out_idx !== 6'd0) begin n_err++; $display("FAIL flush exp idx: got %0d want 0", out_idx); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL flush exp pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
        set_rand();
        push_block();
        run(64, 0, 200, got, cyc);
        n_cmp++; if (got != 64 || cyc != 80) begin n_err++; $display("FAIL flush reload timing: got %0d pairs in %0d cycles want 64 in 80", got, cyc); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL flush reload pair: got %h/%h/%0d want %h/%h/%0d", o.w, o.wp, o.idx, e.w, e.wp, e.idx); end
        end
        exp_q.delete(); obs_q.delete(); in_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc(0);
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_abc(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
